// File: rtl/smg_pkg.sv
// smg_pkg: shared widths, clamp value and converter state encoding for the display path.
package smg_pkg;
   localparam int BIN_W   = 20;
   localparam int DIGITS  = 6;
   localparam int MAX_VAL = 999999;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/bcd_add3_immdmod.sv
// bcd_add3_immdmod: double-dabble digit correction, adds 3 to a nibble of 5 or more.
module bcd_add3_immdmod (
   input  logic [3:0] in_i,
   output logic [3:0] out_o
);
   assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;
endmodule

// File: rtl/bin2bcd_funcmod.sv
// bin2bcd_funcmod: clamped binary-to-BCD converter, one double-dabble shift per clock.
// oData only changes on the oDone cycle so the downstream display never sees partial values.
module bin2bcd_funcmod
   import smg_pkg::*;
#(
   parameter int BIN_W   = smg_pkg::BIN_W,
   parameter int DIGITS  = smg_pkg::DIGITS,
   parameter int MAX_VAL = smg_pkg::MAX_VAL
) (
   input  logic                  CLOCK,
   input  logic                  RESET,
   input  logic                  iStart,
   input  logic [BIN_W-1:0]      iBin,
   output logic [4*DIGITS-1:0]   oData,
   output logic                  oDone,
   output logic                  oBusy,
   output logic                  oOver
);
   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W);
   localparam logic [BIN_W-1:0] MAX_B = BIN_W'(MAX_VAL);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(BIN_W - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]   bin_q;
   logic [BCD_W-1:0]   bcd_q, adj;
   logic [BCD_W-1:0]   data_q;
   logic               done_q, busy_q, over_q, over_cap_q;
   logic [BCD_W+BIN_W-1:0] shift_d;
   logic               over_d;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3_immdmod u_add3 (.in_i(bcd_q[4*g +: 4]), .out_o(adj[4*g +: 4]));
   end

   assign shift_d = {adj, bin_q} << 1;
   assign over_d  = iBin > MAX_B;

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         over_q     <= 1'b0;
         over_cap_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: if (iStart) begin
               bin_q      <= over_d ? MAX_B : iBin;
               bcd_q      <= '0;
               cnt_q      <= '0;
               over_cap_q <= over_d;
               busy_q     <= 1'b1;
               state_q    <= ST_SHIFT;
            end
            ST_SHIFT: begin
               {bcd_q, bin_q} <= shift_d;
               cnt_q          <= cnt_q + 1'b1;
               if (cnt_q == LAST) state_q <= ST_DONE;
            end
            ST_DONE: begin
               data_q  <= bcd_q;
               over_q  <= over_cap_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign oData = data_q;
   assign oDone = done_q;
   assign oBusy = busy_q;
   assign oOver = over_q;
endmodule

// File: tb/tb_bin2bcd_funcmod.sv
// tb_bin2bcd_funcmod: vector table, corner sequences and random values against a decimal-digit model.
module tb_bin2bcd_funcmod;
   logic        CLOCK = 1'b0;
   logic        RESET = 1'b0;
   logic        iStart = 1'b0;
   logic [19:0] iBin = '0;
   logic [23:0] oData;
   logic        oDone, oBusy, oOver;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic [19:0] bin;
      logic [23:0] data;
      logic        over;
   } vec_t;

   vec_t vecs[6];

   always #5 CLOCK = ~CLOCK;

   bin2bcd_funcmod dut (
      .CLOCK(CLOCK), .RESET(RESET), .iStart(iStart), .iBin(iBin),
      .oData(oData), .oDone(oDone), .oBusy(oBusy), .oOver(oOver)
   );

   function automatic logic [23:0] ref_bcd(int v);
      int c = (v > 999999) ? 999999 : v;
      logic [23:0] r = '0;
      for (int i = 0; i < 6; i++) begin
         r[4*i +: 4] = 4'(c % 10);
         c = c / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick;
      @(posedge CLOCK);
      #1;
   endtask

   task automatic convert(input logic [19:0] v, output logic [23:0] d, output logic ov,
                          output int lat, output logic busy1);
      iStart = 1'b1;
      iBin   = v;
      tick();
      iStart = 1'b0;
      busy1  = oBusy;
      lat    = 0;
      do begin
         tick();
         lat++;
      end while (!oDone && lat < 100);
      d  = oData;
      ov = oOver;
   endtask

   initial begin
      logic [23:0] d, hold;
      logic        ov, b1;
      int          lat, dones, m;
      logic [19:0] r;
      vecs[0] = '{20'd0,       24'h000000, 1'b0};
      vecs[1] = '{20'd123456,  24'h123456, 1'b0};
      vecs[2] = '{20'd999999,  24'h999999, 1'b0};
      vecs[3] = '{20'd9,       24'h000009, 1'b0};
      vecs[4] = '{20'hFFFFF,   24'h999999, 1'b1};
      vecs[5] = '{20'd42,      24'h000042, 1'b0};
      tick();
      tick();
      chk("reset data", oData, 0);
      chk("reset done", oDone, 0);
      chk("reset busy", oBusy, 0);
      chk("reset over", oOver, 0);
      RESET = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         convert(vecs[i].bin, d, ov, lat, b1);
         chk($sformatf("vec%0d latency", i), lat, 21);
         chk($sformatf("vec%0d busy", i), b1, 1);
         chk($sformatf("vec%0d data", i), d, vecs[i].data);
         chk($sformatf("vec%0d over", i), ov, vecs[i].over);
         tick();
         chk($sformatf("vec%0d done clear", i), oDone, 0);
         chk($sformatf("vec%0d busy clear", i), oBusy, 0);
         chk($sformatf("vec%0d hold", i), oData, vecs[i].data);
      end
      // start while busy must be ignored
      iStart = 1'b1;
      iBin   = 20'd123;
      tick();
      iStart = 1'b0;
      dones  = 0;
      d      = '0;
      for (int i = 1; i <= 40; i++) begin
         if (i == 5) begin iStart = 1'b1; iBin = 20'd777; end
         if (i == 6) iStart = 1'b0;
         tick();
         if (oDone) begin dones++; d = oData; end
      end
      chk("ignore done count", dones, 1);
      chk("ignore data", d, 24'h000123);
      // reset at cycle 10 of a conversion
      iStart = 1'b1;
      iBin   = 20'd500000;
      tick();
      iStart = 1'b0;
      repeat (10) tick();
      RESET = 1'b0;
      #1;
      chk("abort busy", oBusy, 0);
      chk("abort data", oData, 0);
      chk("abort done", oDone, 0);
      tick();
      RESET = 1'b1;
      dones = 0;
      repeat (30) begin
         tick();
         if (oDone) dones++;
      end
      chk("abort no done", dones, 0);
      chk("abort data held", oData, 0);
      convert(20'd654321, d, ov, lat, b1);
      chk("restart latency", lat, 21);
      chk("restart data", d, 24'h654321);
      tick();
      // back-to-back with iStart held and iBin stepping each clock
      m      = 0;
      hold   = oData;
      iStart = 1'b1;
      for (int c = 0; c < 110; c++) begin
         iBin = 20'(c);
         tick();
         if (oDone) begin
            chk($sformatf("b2b%0d timing", m), c, 22*m + 21);
            chk($sformatf("b2b%0d data", m), oData, ref_bcd(22*m));
            m++;
            hold = oData;
         end else if (oData !== hold) begin
            chk($sformatf("b2b stable c%0d", c), oData, hold);
         end
      end
      iStart = 1'b0;
      chk("b2b result count", m, 5);
      repeat (25) tick();
      // random values against the decimal model
      for (int i = 0; i < 20; i++) begin
         r = 20'($urandom_range(0, 1048575));
         if (i == 0) r = 20'd1000000;
         convert(r, d, ov, lat, b1);
         chk($sformatf("rnd%0d latency", i), lat, 21);
         chk($sformatf("rnd%0d data v=%0d", i, r), d, ref_bcd(int'(r)));
         chk($sformatf("rnd%0d over v=%0d", i, r), ov, (r > 20'd999999));
         tick();
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
